// File: rtl/id_branch_resolve.sv
// ID-stage beq/bne resolution with a two-state stall FSM covering load-use and ALU-use branch hazards.
// Define BRANCH_STATS_EN to add saturating branch/taken/stall-cycle counters.
module id_branch_resolve #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_is_branch,
  input  logic          id_branch_ne,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [DW-1:0] id_pc_plus4,
  input  logic [15:0]   id_imm,
  input  logic [DW-1:0] ex2mem_alu_result,
  input  logic          fw_rs,
  input  logic          fw_rt,
  input  logic          id2ex_regWrite,
  input  logic          id2ex_memRead,
  input  logic [4:0]    id2ex_writeRegister,
  input  logic          ex2mem_memRead,
  input  logic [4:0]    ex2mem_writeRegister,
  output logic          pc_write,
  output logic          if2id_write,
  output logic          id2ex_bubble,
  output logic          pc_src,
  output logic [DW-1:0] branch_target,
  output logic          if2id_flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_taken,
  output logic [31:0]   stat_stall_cycles
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state, nextState;
  logic [DW-1:0] opA, opB, immExt;
  logic          br, eq, hazH2, hazH1a, hazH1b, stall;

  function automatic logic usesReg(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    opA           = fw_rs ? ex2mem_alu_result : rs_data;
    opB           = fw_rt ? ex2mem_alu_result : rt_data;
    eq            = (opA == opB);
    br            = id_valid & id_is_branch;
    immExt        = {{(DW-16){id_imm[15]}}, id_imm};
    branch_target = id_pc_plus4 + (immExt << 2);

    hazH2  = br & id2ex_memRead & usesReg(id2ex_writeRegister, id_rs, id_rt);
    hazH1a = br & id2ex_regWrite & ~id2ex_memRead
           & usesReg(id2ex_writeRegister, id_rs, id_rt);
    hazH1b = br & ex2mem_memRead & usesReg(ex2mem_writeRegister, id_rs, id_rt);
  end

  // Single-cycle hazards simply hold in IDLE; the producer advances and the check re-fires.
  always_comb begin
    nextState = IDLE;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        stall = hazH2 | hazH1a | hazH1b;
        if (hazH2) nextState = HOLD;
      end
      HOLD: begin
        stall     = 1'b1;
        nextState = IDLE;
      end
      default: begin
        stall     = 1'b0;
        nextState = IDLE;
      end
    endcase
    if (!id_valid) nextState = IDLE;

    pc_write     = ~stall;
    if2id_write  = ~stall;
    id2ex_bubble = stall;
    pc_src       = br & ~stall & (eq ^ id_branch_ne);
    if2id_flush  = pc_src;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches     <= '0;
      stat_taken        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (br && !stall && (stat_branches != '1))  stat_branches     <= stat_branches + 32'd1;
      if (pc_src && (stat_taken != '1))           stat_taken        <= stat_taken + 32'd1;
      if (stall && (stat_stall_cycles != '1))     stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
